// File: rtl/tile_select_ctrl.sv
// Player input front-end: debounces the three board buttons, walks a tile cursor over the
// 16 positions, issues the confirmed tile with a one-cycle select strobe and then holds a
// timed reveal window before the next selection is accepted.
module tile_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REVEAL_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  input  logic       enable,
  output logic [3:0] cursor,
  output logic [3:0] position_data,
  output logic       A,
  output logic       reveal,
  output logic       reveal_done,
  output logic       busy
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RvW = $clog2(REVEAL_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RvW-1:0] RvLast = RvW'(REVEAL_CYCLES - 1);

  // Button index: 0 = left, 1 = right, 2 = ok.
  logic [2:0] raw;
  assign raw = {btn_ok, btn_right, btn_left};

  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     level_q, level_d, level_dly_q;
  logic [2:0]     press_q;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  // Two-flop synchronisers for the asynchronous raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip the level once the count is reached.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounced level, its delayed copy and the registered rising-edge press pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  logic press_left, press_right, press_ok;
  assign press_left  = press_q[0];
  assign press_right = press_q[1];
  assign press_ok    = press_q[2];

  typedef enum logic [1:0] {StIdle, StSelect, StIssue, StReveal} state_e;

  state_e         state_q, state_d;
  logic [RvW-1:0] rv_cnt_q, rv_cnt_d;
  logic [3:0]     cursor_q, cursor_d;
  logic [3:0]     pos_q, pos_d;
  logic           done_q, done_d;

  // State, reveal timer, cursor and latched tile registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rv_cnt_q <= '0;
      cursor_q <= '0;
      pos_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rv_cnt_q <= rv_cnt_d;
      cursor_q <= cursor_d;
      pos_q    <= pos_d;
      done_q   <= done_d;
    end
  end

  // Next state: enable low wins from any state and silently aborts a reveal in progress.
  always_comb begin
    state_d  = state_q;
    rv_cnt_d = rv_cnt_q;
    cursor_d = cursor_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    if (!enable) begin
      state_d  = StIdle;
      rv_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSelect;
        end
        StSelect: begin
          // Confirm takes priority; simultaneous left/right cancel out.
          if (press_ok) begin
            pos_d   = cursor_q;
            state_d = StIssue;
          end else if (press_left && !press_right) begin
            cursor_d = cursor_q - 4'd1;
          end else if (press_right && !press_left) begin
            cursor_d = cursor_q + 4'd1;
          end
        end
        StIssue: begin
          state_d  = StReveal;
          rv_cnt_d = '0;
        end
        StReveal: begin
          if (rv_cnt_q == RvLast) begin
            state_d  = StSelect;
            rv_cnt_d = '0;
            done_d   = 1'b1;
          end else begin
            rv_cnt_d = rv_cnt_q + RvW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs decode straight from registers so reset clears them asynchronously.
  always_comb begin
    A             = (state_q == StIssue);
    reveal        = (state_q == StReveal);
    busy          = (state_q == StIssue) || (state_q == StReveal);
    reveal_done   = done_q;
    cursor        = cursor_q;
    position_data = pos_q;
  end

endmodule

// File: tb/tb_tile_select_ctrl.sv
// Bench for tile_select_ctrl: directed scenarios followed by random button/enable activity,
// every cycle compared against a behavioural model of the player front-end.
module tb_tile_select_ctrl;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk;
  logic       rst;
  logic       btn_left, btn_right, btn_ok, enable;
  logic [3:0] cursor, position_data;
  logic       A, reveal, reveal_done, busy;

  int checks = 0;
  int errors = 0;

  tile_select_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REVEAL_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_ok       (btn_ok),
    .enable       (enable),
    .cursor       (cursor),
    .position_data(position_data),
    .A            (A),
    .reveal       (reveal),
    .reveal_done  (reveal_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. Buttons: 0 left, 1 right, 2 ok. Modes: idle/select/issue/reveal.
  localparam int MIdle   = 0;
  localparam int MSelect = 1;
  localparam int MIssue  = 2;
  localparam int MReveal = 3;

  int m_s1 [3];
  int m_s2 [3];
  int m_lvl [3];
  int m_prev [3];
  int m_run [3];
  int m_pulse [3];
  int m_mode, m_left, m_cur, m_pos, m_done;

  function automatic void m_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_run[b] = 0; m_pulse[b] = 0;
    end
    m_mode = MIdle; m_left = 0; m_cur = 0; m_pos = 0; m_done = 0;
  endfunction

  function automatic void m_edge();
    int raw [3];
    if (!rst) begin
      m_reset();
      return;
    end
    raw[0] = int'(btn_left); raw[1] = int'(btn_right); raw[2] = int'(btn_ok);
    m_done = 0;
    if (!enable) begin
      m_mode = MIdle;
    end else if (m_mode == MIdle) begin
      m_mode = MSelect;
    end else if (m_mode == MSelect) begin
      if (m_pulse[2] != 0) begin
        m_pos  = m_cur;
        m_mode = MIssue;
      end else if (m_pulse[0] != 0 && m_pulse[1] == 0) begin
        m_cur = (m_cur + 15) % 16;
      end else if (m_pulse[1] != 0 && m_pulse[0] == 0) begin
        m_cur = (m_cur + 1) % 16;
      end
    end else if (m_mode == MIssue) begin
      m_mode = MReveal;
      m_left = R;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = MSelect;
        m_done = 1;
      end
    end
    // Button front-end: two-sample delay, then a level that follows after D disagreeing cycles.
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = (m_lvl[b] == 1 && m_prev[b] == 0) ? 1 : 0;
      m_prev[b]  = m_lvl[b];
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_lvl[b] = 1 - m_lvl[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("cursor", 8'(cursor), 8'(m_cur));
    chk("position_data", 8'(position_data), 8'(m_pos));
    chk("A", 8'(A), 8'(m_mode == MIssue));
    chk("reveal", 8'(reveal), 8'(m_mode == MReveal));
    chk("reveal_done", 8'(reveal_done), 8'(m_done));
    chk("busy", 8'(busy), 8'(m_mode == MIssue || m_mode == MReveal));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) btn_left = v;
    else if (b == 1) btn_right = v;
    else btn_ok = v;
  endtask

  // Clean press: hold long enough to register, release and let the release settle.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    ticks(D + 5);
    set_btn(b, 1'b0);
    ticks(D + 4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cursor"}, 8'(cursor), 8'd0);
    chk({tag, "_pos"}, 8'(position_data), 8'd0);
    chk({tag, "_A"}, 8'(A), 8'd0);
    chk({tag, "_reveal"}, 8'(reveal), 8'd0);
    chk({tag, "_done"}, 8'(reveal_done), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  int hold [3];
  int en_hold;

  initial begin
    rst = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_ok = 1'b0; enable = 1'b0;
    m_reset();
    #1;
    chk_all_zero("reset");
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // First press: cursor moves on the 8th edge after the raw rise (pulse in cycle 7).
    enable = 1'b1;
    tick();
    btn_right = 1'b1;
    ticks(7);
    chk("first_press_before", 8'(cursor), 8'd0);
    tick();
    chk("first_press_after", 8'(cursor), 8'd1);
    ticks(12);
    btn_right = 1'b0;
    ticks(D + 4);
    chk("held_single_press", 8'(cursor), 8'd1);

    // Bounce: toggling every 2 cycles never satisfies the debounce count.
    for (int i = 0; i < 10; i++) begin
      btn_right = ~btn_right;
      ticks(2);
    end
    btn_right = 1'b0;
    ticks(10);
    chk("bounce_no_move", 8'(cursor), 8'd1);

    // Wrap both ways.
    press(0);
    chk("left_to_0", 8'(cursor), 8'd0);
    press(0);
    chk("wrap_0_to_15", 8'(cursor), 8'd15);
    press(1);
    chk("wrap_15_to_0", 8'(cursor), 8'd0);
    for (int i = 0; i < 5; i++) press(1);
    chk("cursor_5", 8'(cursor), 8'd5);

    // Confirm at 5: one-cycle strobe, 8-cycle reveal, right press during reveal ignored.
    btn_ok = 1'b1;
    ticks(7);
    chk("ok_A_early", 8'(A), 8'd0);
    tick();
    chk("ok_A", 8'(A), 8'd1);
    chk("ok_pos", 8'(position_data), 8'd5);
    btn_ok = 1'b0;
    btn_right = 1'b1;
    for (int i = 0; i < R; i++) begin
      tick();
      chk("reveal_window", 8'(reveal), 8'd1);
    end
    tick();
    chk("reveal_end", 8'(reveal), 8'd0);
    chk("reveal_done_pulse", 8'(reveal_done), 8'd1);
    chk("reveal_cursor_kept", 8'(cursor), 8'd5);
    tick();
    chk("reveal_done_once", 8'(reveal_done), 8'd0);
    btn_right = 1'b0;
    ticks(D + 4);

    // Enable drops in the third reveal cycle: silent abort, cursor retained.
    btn_ok = 1'b1;
    ticks(8);
    btn_ok = 1'b0;
    ticks(3);
    chk("abort_in_reveal", 8'(reveal), 8'd1);
    enable = 1'b0;
    tick();
    chk("abort_reveal_low", 8'(reveal), 8'd0);
    chk("abort_no_done", 8'(reveal_done), 8'd0);
    ticks(12);
    enable = 1'b1;
    tick();
    chk("reenable_cursor", 8'(cursor), 8'd5);
    press(1);
    chk("reenable_select", 8'(cursor), 8'd6);

    // Asynchronous reset mid-reveal.
    btn_ok = 1'b1;
    ticks(8);
    btn_ok = 1'b0;
    ticks(2);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    tick();
    chk("post_rst_cursor", 8'(cursor), 8'd0);
    chk("post_rst_pos", 8'(position_data), 8'd0);

    // Random buttons (mix of bounces and clean holds) with occasional enable drops.
    for (int b = 0; b < 3; b++) hold[b] = 0;
    en_hold = 0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          set_btn(b, logic'($urandom_range(0, 1)));
          hold[b] = int'($urandom_range(1, 14));
        end else begin
          hold[b]--;
        end
      end
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) enable = 1'b1;
      end else if ($urandom_range(0, 63) == 0) begin
        enable = 1'b0;
        en_hold = int'($urandom_range(1, 6));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_select_ctrl.md
# tile_select_ctrl

Player input front-end for the Chicken Cha-Cha-Cha board. It synchronises and debounces the three raw push-buttons and moves a tile cursor over the 16 board positions. On confirm, it issues the selected `position_data` with a one-cycle `A` select strobe to the data path, then holds a timed reveal window before accepting the next selection. It sits directly upstream of the data path and drives its `position_data` and `A` inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a button level is accepted; must be ≥1.
- `REVEAL_CYCLES`, default 50000000: length of the reveal window in clk cycles; must be ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_left`  in  1  raw button, active-high, asynchronous to clk.
- `btn_right`  in  1  raw button, active-high, asynchronous to clk.
- `btn_ok`  in  1  raw button, active-high, asynchronous to clk.
- `enable`  in  1  game is active and the data path accepts selections.
- `cursor`  out  4  current highlighted tile, 0–15.
- `position_data`  out  4  tile latched at confirm; feeds the data path.
- `A`  out  1  one-cycle select strobe; `position_data` is valid while `A` is high.
- `reveal`  out  1  high during the reveal window.
- `reveal_done`  out  1  one-cycle pulse when the reveal window ends.
- `busy`  out  1  high in ISSUE and REVEAL.

## Operation
- Each button path:
  - 2-FF synchroniser.
  - Debounce counter: counts consecutive cycles in which the synced value differs from the debounced level; resets to 0 on any agreement.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - A press pulse is the registered rising edge of the debounced level.
  - Releases produce no pulse.
- FSM states:
  - IDLE: `enable`=0. All presses are discarded. Go to SELECT when `enable`=1.
  - SELECT:
    - left press: cursor−1, mod 16 (0→15).
    - right press: cursor+1, mod 16 (15→0).
    - left and right pulses in the same cycle: no move.
    - ok press: go to ISSUE. The cursor does not move, even if left/right pulse in the same cycle.
  - ISSUE: exactly one cycle. `A`=1, `position_data` = cursor value at entry. Go to REVEAL.
  - REVEAL: `reveal`=1 for exactly `REVEAL_CYCLES` cycles. All presses are discarded and not queued. On expiry go to SELECT and pulse `reveal_done`.
- `enable` falling in any state: go to IDLE on the next edge. Clear `reveal`, abort the reveal counter, do not pulse `A` or `reveal_done`.
- `cursor` and `position_data` retain their values across IDLE; only reset clears them.
- Reset values: state IDLE, `cursor`=0, `position_data`=0, `A`=0, `reveal`=0, `reveal_done`=0, `busy`=0, all debounced levels 0, all counters 0.
- Reset assertion mid-operation: every output takes its reset value immediately, asynchronously.

## Timing
- Raw button held high from edge 0: its press pulse is high in cycle `DEBOUNCE_CYCLES`+3 (2 sync + debounce + edge register).
- Cursor update: the cursor register changes on the edge after the press pulse.
- Ok press pulse in cycle t (SELECT): `A`=1 in cycle t+1; `reveal`=1 in cycles t+2 … t+1+`REVEAL_CYCLES`.
- Reveal end: `reveal_done`=1 in cycle t+2+`REVEAL_CYCLES`, with the state already SELECT. A press pulse in that same cycle is acted on.
- `busy` is high in exactly the cycles where `A` or `reveal` is high.
- Counter widths: `$clog2(param+1)`; no overflow is permitted.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4 and `REVEAL_CYCLES`=8.
- Reset then `enable`=1, right held 20 cycles: exactly one press. `cursor` 0→1, with the press pulse in cycle 7 after the raw edge.
- Bounce: `btn_right` toggles every 2 cycles for 20 cycles, then goes low. No press pulse; `cursor` unchanged.
- Wrap: from cursor 0, one left press → 15. From 15, one right press → 0.
- Cursor 5, ok press: `A`=1 for exactly 1 cycle with `position_data`=5. `reveal` is high for exactly 8 cycles, then `reveal_done` pulses once. Right presses during REVEAL do not move the cursor.
- `enable` drops in the 3rd reveal cycle: `reveal`=0 next cycle; no `reveal_done`; state IDLE. `enable` re-raised → SELECT with `cursor` still 5.
- `rst` asserted low mid-REVEAL: all outputs 0 immediately. After release, `cursor`=0 and `position_data`=0.
